// File: rtl/cpu_68k_busctl.sv
// cpu_68k_busctl: 68000 phase-enable generator, reset stretcher, IPL synchroniser and bus-acknowledge FSM.
// The optional bus watchdog (BERR on missing acknowledge, sticky TIMEOUT_FLAG) is built only when
// the macro CPU68K_WATCHDOG_EN is defined; otherwise nBERR is tied high and TIMEOUT_FLAG tied low.
module cpu_68k_busctl #(
   parameter int         CLK_DIV      = 2,
   parameter int         RESET_HOLD   = 16,
   parameter int         WDOG_LIMIT   = 255,
   parameter logic [6:0] AUTOVEC_MASK = 7'h7F
) (
   input  logic       CLK_24M,
   input  logic       nRESET,
   output logic       EN_PHI1,
   output logic       EN_PHI2,
   output logic       CPU_RESET,
   input  logic       nAS,
   input  logic [2:0] FC,
   input  logic [2:0] ADDR_LO,
   input  logic       nDTACK_IN,
   input  logic [3:0] WAIT_STATES,
   input  logic [2:0] IPL_IN,
   output logic       nDTACK_OUT,
   output logic       nVPA,
   output logic       nBERR,
   output logic [2:0] IPL_OUT,
   output logic       TIMEOUT_FLAG
);
   localparam int PW = $clog2(CLK_DIV);
   localparam int RW = $clog2(RESET_HOLD + 1);
   typedef enum logic [2:0] {IDLE, WAIT_ACK, WSTATE, ACK, AVEC, BERR} state_t;
   if (CLK_DIV < 2 || CLK_DIV > 16 || CLK_DIV % 2 != 0 || RESET_HOLD < 1 || WDOG_LIMIT < 1) begin : g_bad_param
      $error("cpu_68k_busctl: parameter out of range");
   end
   state_t        state;
   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;
   logic [RW-1:0] rst_cnt;
   logic [3:0]    wait_cnt;
   logic [2:0]    ipl_meta;
   logic [7:0]    avec_map;
   logic          as_q;
   logic          as_fall;
   logic          autovec;
   logic          wd_trip;
   assign phase_nxt = (phase == PW'(CLK_DIV - 1)) ? '0 : phase + 1'b1;
   assign as_fall   = as_q & ~nAS;
   assign avec_map  = {AUTOVEC_MASK, 1'b0};
   assign autovec   = (FC == 3'b111) && avec_map[ADDR_LO];
   // Phase counter; enables are registered from the next count so reset holds both low
   always_ff @(posedge CLK_24M or negedge nRESET)
      if (!nRESET) begin
         phase   <= '0;
         EN_PHI1 <= 1'b0;
         EN_PHI2 <= 1'b0;
      end else begin
         phase   <= phase_nxt;
         EN_PHI1 <= (phase_nxt == '0);
         EN_PHI2 <= (phase_nxt == PW'(CLK_DIV / 2));
      end
   // Stretch CPU reset for RESET_HOLD PHI2 pulses after nRESET release
   always_ff @(posedge CLK_24M or negedge nRESET)
      if (!nRESET) begin
         CPU_RESET <= 1'b1;
         rst_cnt   <= '0;
      end else if (CPU_RESET && EN_PHI2) begin
         rst_cnt <= rst_cnt + 1'b1;
         if (rst_cnt == RW'(RESET_HOLD - 1)) CPU_RESET <= 1'b0;
      end
   // Two-stage interrupt level synchroniser clocked by the PHI2 enable
   always_ff @(posedge CLK_24M or negedge nRESET)
      if (!nRESET) begin
         ipl_meta <= 3'b111;
         IPL_OUT  <= 3'b111;
      end else if (EN_PHI2) begin
         ipl_meta <= IPL_IN;
         IPL_OUT  <= ipl_meta;
      end
   // Bus FSM; a cycle starts only on a sampled nAS fall so a reset never resumes a stale cycle
   always_ff @(posedge CLK_24M or negedge nRESET)
      if (!nRESET) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         as_q       <= 1'b0;
         nDTACK_OUT <= 1'b1;
         nVPA       <= 1'b1;
      end else begin
         as_q       <= nAS;
         nDTACK_OUT <= (state != ACK);
         nVPA       <= (state != AVEC);
         case (state)
            IDLE:     if (as_fall) state <= autovec ? AVEC : WAIT_ACK;
            WAIT_ACK: if (nAS) state <= IDLE;
                      else if (!nDTACK_IN) begin
                         state    <= (WAIT_STATES == 4'd0) ? ACK : WSTATE;
                         wait_cnt <= WAIT_STATES;
                      end else if (wd_trip) state <= BERR;
            WSTATE:   if (nAS) state <= IDLE;
                      else if (EN_PHI2 && wait_cnt == 4'd1) state <= ACK;
                      else if (wd_trip) state <= BERR;
                      else if (EN_PHI2) wait_cnt <= wait_cnt - 4'd1;
            default:  if (nAS) state <= IDLE;
         endcase
      end
`ifdef CPU68K_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_LIMIT + 1);
   logic [WW-1:0] wd_cnt;
   logic          wd_wait;
   assign wd_wait = (state == WAIT_ACK) || (state == WSTATE);
   assign wd_trip = EN_PHI2 && !nAS && (wd_cnt == WW'(WDOG_LIMIT - 1)) &&
                    ((state == WAIT_ACK && nDTACK_IN) || (state == WSTATE && wait_cnt != 4'd1));
   // Watchdog counts PHI2 pulses while waiting for an acknowledge; timeout flag is sticky
   always_ff @(posedge CLK_24M or negedge nRESET)
      if (!nRESET) begin
         wd_cnt       <= '0;
         nBERR        <= 1'b1;
         TIMEOUT_FLAG <= 1'b0;
      end else begin
         nBERR <= (state != BERR);
         if (state == IDLE) wd_cnt <= '0;
         else if (wd_wait && EN_PHI2) wd_cnt <= wd_cnt + 1'b1;
         if (wd_trip) TIMEOUT_FLAG <= 1'b1;
      end
`else
   assign wd_trip      = 1'b0;
   assign nBERR        = 1'b1;
   assign TIMEOUT_FLAG = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_68k_busctl.sv
// tb_cpu_68k_busctl: directed plus randomized bench for cpu_68k_busctl (CLK_DIV=4, WDOG_LIMIT=8, AUTOVEC_MASK=7'h08).
module tb_cpu_68k_busctl;
   localparam int         D  = 4;
   localparam int         H  = 16;
   localparam int         WL = 8;
   localparam logic [6:0] AM = 7'h08;
   logic       CLK_24M = 1'b0, nRESET = 1'b0, nAS = 1'b1, nDTACK_IN = 1'b1;
   logic [2:0] FC = 3'd0, ADDR_LO = 3'd0, IPL_IN = 3'b111;
   logic [3:0] WAIT_STATES = 4'd0;
   logic       EN_PHI1, EN_PHI2, CPU_RESET, nDTACK_OUT, nVPA, nBERR, TIMEOUT_FLAG;
   logic [2:0] IPL_OUT;
   logic [2:0] fc_tab [4] = '{3'b101, 3'b110, 3'b001, 3'b111};
   int n, checks, errs;

   cpu_68k_busctl #(.CLK_DIV(D), .RESET_HOLD(H), .WDOG_LIMIT(WL), .AUTOVEC_MASK(AM)) dut (
      .CLK_24M(CLK_24M), .nRESET(nRESET), .EN_PHI1(EN_PHI1), .EN_PHI2(EN_PHI2), .CPU_RESET(CPU_RESET),
      .nAS(nAS), .FC(FC), .ADDR_LO(ADDR_LO), .nDTACK_IN(nDTACK_IN), .WAIT_STATES(WAIT_STATES),
      .IPL_IN(IPL_IN), .nDTACK_OUT(nDTACK_OUT), .nVPA(nVPA), .nBERR(nBERR), .IPL_OUT(IPL_OUT),
      .TIMEOUT_FLAG(TIMEOUT_FLAG));

   always #5 CLK_24M = ~CLK_24M;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_phi"}, 8'({EN_PHI1, EN_PHI2}), 8'd0);
      chk({tag, "_cpu_reset"}, 8'(CPU_RESET), 8'd1);
      chk({tag, "_resp"}, 8'({nDTACK_OUT, nVPA, nBERR}), 8'd7);
      chk({tag, "_ipl"}, 8'(IPL_OUT), 8'd7);
      chk({tag, "_timeout"}, 8'(TIMEOUT_FLAG), 8'd0);
   endtask

   // one rising edge, then sit at the following falling edge to sample and drive
   task automatic cyc();
      @(posedge CLK_24M);
      n++;
      @(negedge CLK_24M);
   endtask

   // edge e (counted from reset release) sees the PHI2 enable that was set after edge e-1
   function automatic bit phi2_at(input int e);
      return e >= 2 && (e - 1) % D == D / 2;
   endfunction

   function automatic bit is_avec(input logic [2:0] fc, input logic [2:0] a);
      return fc == 3'b111 && a != 3'd0 && ((AM >> (a - 3'd1)) & 7'd1) != 7'd0;
   endfunction

   // edge after which the response is visible, for a cycle whose nAS fall is sampled at edge k
   function automatic int resp_edge(input int k, input bit av, input int w);
      int e, p;
      if (av) return k + 1;
      if (w == 0) return k + 2;
      p = 0;
      for (e = k + 2; e < k + 500; e++) begin
         if (phi2_at(e)) p++;
         if (p == w) break;
      end
      return e + 1;
   endfunction

   task automatic bus(input logic [2:0] fc, input logic [2:0] a, input int w, input bit drop);
      int k, exp_e, got;
      bit av, other_low;
      av = is_avec(fc, a);
      nAS = 1'b0; FC = fc; ADDR_LO = a; WAIT_STATES = 4'(w); nDTACK_IN = av;
      k = n + 1;
      exp_e = resp_edge(k, av, w);
      got = -1;
      other_low = 1'b0;
      for (int i = 0; i < 100 && got < 0; i++) begin
         cyc();
         if (drop && n == k + 1) nDTACK_IN = 1'b1;
         if ((av ? nDTACK_OUT : nVPA) == 1'b0) other_low = 1'b1;
         if ((av ? nVPA : nDTACK_OUT) == 1'b0) got = n;
      end
      chk(av ? "avec_latency" : "ack_latency", 8'(got - k), 8'(exp_e - k));
      chk("other_resp_high", 8'(other_low), 8'd0);
      nAS = 1'b1; nDTACK_IN = 1'b1;
      cyc();
      cyc();
      chk("resp_release", 8'({nDTACK_OUT, nVPA}), 8'd3);
   endtask

   task automatic ipl_step(input logic [2:0] v);
      logic [2:0] old;
      int c, e1, e2;
      repeat (2 * D + 2) cyc();
      old = IPL_OUT;
      IPL_IN = v;
      c = n + 1;
      for (e1 = c; !phi2_at(e1); e1++) ;
      for (e2 = e1 + 1; !phi2_at(e2); e2++) ;
      while (n < e2 - 1) cyc();
      chk("ipl_hold", 8'(IPL_OUT), 8'(old));
      cyc();
      chk("ipl_sync", 8'(IPL_OUT), 8'(v));
   endtask

   initial begin
      int k, exp_e, got;
      bit bad;
      n = 0; checks = 0; errs = 0;
      repeat (3) @(negedge CLK_24M);
      chk_reset("reset");
      nRESET = 1'b1;
      n = 0;
      repeat (70) begin
         cyc();
         chk("phi1", 8'(EN_PHI1), 8'(n % D == 0));
         chk("phi2", 8'(EN_PHI2), 8'(n % D == D / 2));
         chk("cpu_reset", 8'(CPU_RESET), 8'(n < D / 2 + (H - 1) * D + 1));
      end
      bus(3'b101, 3'd0, 3, 1'b0);
      bus(3'b101, 3'd1, 3, 1'b1);
      bus(3'b111, 3'd4, 0, 1'b0);
      bus(3'b111, 3'd2, 0, 1'b0);
      bus(3'b110, 3'd5, 0, 1'b0);
      repeat (16) begin
         repeat ($urandom_range(1, 3)) cyc();
         bus(fc_tab[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
             1'($urandom_range(0, 1)));
      end
      ipl_step(3'b010);
      repeat (3) ipl_step(IPL_OUT ^ 3'($urandom_range(1, 7)));
      // acknowledge never arrives
      nAS = 1'b0; FC = 3'b101; ADDR_LO = 3'd0; WAIT_STATES = 4'd0; nDTACK_IN = 1'b1;
      k = n + 1;
      bad = 1'b0;
`ifdef CPU68K_WATCHDOG_EN
      begin
         int p, e;
         p = 0;
         for (e = k + 1; e < k + 500; e++) begin
            if (phi2_at(e)) p++;
            if (p == WL) break;
         end
         exp_e = e + 1;
      end
      got = -1;
      for (int i = 0; i < 300 && got < 0; i++) begin
         cyc();
         if (!nDTACK_OUT || !nVPA) bad = 1'b1;
         if (!nBERR) got = n;
      end
      chk("berr_latency", 8'(got - k), 8'(exp_e - k));
      chk("berr_no_dtack", 8'(bad), 8'd0);
      chk("timeout_set", 8'(TIMEOUT_FLAG), 8'd1);
      nAS = 1'b1;
      cyc();
      cyc();
      chk("berr_release", 8'(nBERR), 8'd1);
      repeat (5) cyc();
      chk("timeout_sticky", 8'(TIMEOUT_FLAG), 8'd1);
`else
      repeat (80) begin
         cyc();
         if (!nDTACK_OUT || !nBERR || !nVPA) bad = 1'b1;
      end
      chk("no_wdog_resp", 8'(bad), 8'd0);
      chk("timeout_off", 8'(TIMEOUT_FLAG), 8'd0);
      nAS = 1'b1;
      cyc();
      cyc();
`endif
      // abort in wait states, then reset in the middle of a new cycle
      nAS = 1'b0; FC = 3'b101; WAIT_STATES = 4'd6; nDTACK_IN = 1'b0;
      bad = 1'b0;
      repeat (3) begin
         cyc();
         if (!nDTACK_OUT) bad = 1'b1;
      end
      nAS = 1'b1;
      repeat (2) begin
         cyc();
         if (!nDTACK_OUT) bad = 1'b1;
      end
      chk("abort_no_dtack", 8'(bad), 8'd0);
      nAS = 1'b0;
      repeat (2) cyc();
      nRESET = 1'b0;
      #1;
      chk_reset("midcycle_reset");
      repeat (2) cyc();
      nRESET = 1'b1;
      n = 0;
      bad = 1'b0;
      repeat (30) begin
         cyc();
         if (!nDTACK_OUT || !nVPA) bad = 1'b1;
      end
      chk("post_reset_no_resp", 8'(bad), 8'd0);
      nAS = 1'b1; nDTACK_IN = 1'b1;
      cyc();
      bus(3'b101, 3'd0, 0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
